dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of the word-addressed data memory.
//  Port 0 = core load/store path; port 1 = loader/debug DMA.
//  Accepts one request at a time and drives the memory's address/write-data/write-enable.
//  Returns the read word, or a write acknowledge, with an error flag for misaligned or
//  out-of-range addresses.
// PARAMETERS
//  MEM_WORDS  4096  memory depth in 32-bit words; legal byte addresses are 0 .. 4*MEM_WORDS-1
//  IDX_W      12    word-index width (= clog2(MEM_WORDS)); mem_addr[IDX_W+1:2] selects the word
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst          in   1   synchronous active-high reset
//  req_valid    in   2   per-port request valid (bit i = port i)
//  req_ready    out  2   per-port request accept; handshake when valid&ready high in same cycle
//  req_we0      in   1   port 0: 1 = write, 0 = read
//  req_addr0    in   32  port 0 byte address
//  req_wdata0   in   32  port 0 write data
//  req_we1      in   1   port 1: 1 = write, 0 = read
//  req_addr1    in   32  port 1 byte address
//  req_wdata1   in   32  port 1 write data
//  rsp_valid    out  2   one-cycle response strobe to the port that issued the request
//  rsp_rdata    out  32  read data (0 for writes and errors), valid while any rsp_valid bit is 1
//  rsp_err      out  1   1 = request was misaligned or out of range, valid with rsp_valid
//  mem_addr     out  32  byte address to data memory
//  mem_wdata    out  32  write data to data memory
//  mem_we       out  1   write enable to data memory
//  mem_rdata    in   32  asynchronous read data from data memory
// BEHAVIOUR
//  FSM states: IDLE -> ACCESS -> RESP -> IDLE. One transaction is in flight at most.
//  Reset values:
//   - state = IDLE; last_grant = 1, so port 0 wins the first tie.
//   - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
//   - mem_we = 0; mem_addr and mem_wdata = 0.
//   - Latched request (addr, wdata, we, port) = 0.
//  IDLE:
//   - req_ready is combinational.
//   - If exactly one valid bit is set, that port's ready = 1.
//   - If both are set, the ready goes to the port != last_grant.
//   - The other ready = 0. No ready is asserted outside IDLE.
//  On handshake:
//   - Latch addr/wdata/we/port and set last_grant = port.
//   - err = (addr[1:0] != 0) | (addr >= 4*MEM_WORDS).
//   - Go to ACCESS.
//  ACCESS (exactly one cycle):
//   - mem_addr and mem_wdata come from the latch.
//   - mem_we = latched_we & ~err & ~rst.
//   - For a read, capture mem_rdata into rsp_rdata at the end of this cycle.
//   - rsp_rdata = 0 for a write or on error.
//   - Go to RESP.
//  RESP (exactly one cycle):
//   - rsp_valid[port] = 1, other bit 0; rsp_err = latched err.
//   - mem_we = 0. Go to IDLE.
//  Latency: handshake in cycle T -> memory access in T+1 -> rsp_valid in T+2.
//   - Next handshake is possible at T+3.
//   - Peak throughput is one access per 3 cycles.
//  Outside ACCESS: mem_we = 0; mem_addr and mem_wdata hold their last latched values.
//  Fairness: under continuous requests from both ports, grants alternate 0,1,0,1...
//   - No port waits more than one transaction.
//  A request dropped (req_valid deasserted) before handshake is ignored; nothing is latched.
//  Errored requests never write memory but still get a response (rsp_err = 1).
//  Address wrap: no aliasing. Addresses at or above 4*MEM_WORDS flag an error rather
//   than truncating.
//  Reset mid-transaction:
//   - rst in any state returns to IDLE next edge with no response issued.
//   - rst during ACCESS forces mem_we = 0 in that cycle.
//   - last_grant returns to 1.
// TESTING
//  1) Reset, then port0 writes 0x2000 = 0xDEADBEEF, then reads 0x2000
//     -> word 2048 written once; read rsp_valid=2'b01 at T+2 with rdata 0xDEADBEEF, err=0.
//  2) Both ports request every cycle from reset, with distinct addresses
//     -> grant order 0,1,0,1; each rsp_valid arrives on the correct bit; no two handshakes
//        closer than 3 cycles.
//  3) Port1 writes to 0x2002 (misaligned) and to 0x4000 (= 4*MEM_WORDS)
//     -> mem_we never asserted; rsp_err=1, rdata=0 for both.
//  4) Port0 issues a write; rst asserted in its ACCESS cycle
//     -> mem_we=0 that cycle; memory unchanged; no rsp_valid; state IDLE; next tie grants port 0.
//  5) Port1 holds req_valid continuously while port0 pulses once
//     -> port0 is served within one transaction of asserting; port1 gets ready only in IDLE.
//  6) Port0 reads 0x3FFC (last word) with preloaded value 10
//     -> rsp_rdata=10, err=0; port1 read of 0x0 right after returns 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter/sequencer for the word-addressed data memory
module dmem_arbiter #(
    parameter int MEM_WORDS = 4096,
    parameter int IDX_W     = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic        req_we0,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_wdata0,
    input  logic        req_we1,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata1,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // First illegal byte address; kept 33 bits wide so the compare never wraps.
    localparam logic [32:0] LIMIT = 33'(4 * MEM_WORDS);

    state_t      state;
    logic        last_grant;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic        lat_port;
    logic        lat_err;

    logic [1:0]  grant;
    logic [1:0]  hs_bits;
    logic        hs_port;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;

    // Grant selection: only in IDLE; on a tie the port that did not win last time goes.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE && !rst) begin
            if (req_valid == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign req_ready = grant;
    assign hs_bits   = req_valid & grant;
    assign hs_port   = hs_bits[1];
    assign sel_we    = hs_port ? req_we1    : req_we0;
    assign sel_addr  = hs_port ? req_addr1  : req_addr0;
    assign sel_wdata = hs_port ? req_wdata1 : req_wdata0;

    // Upper-bit check and range compare together reject anything that would alias.
    assign sel_err = (sel_addr[1:0] != 2'b00)
                   | (|sel_addr[31:IDX_W+2])
                   | ({1'b0, sel_addr} >= LIMIT);

    // Memory strobe is combinational so a reset arriving in ACCESS kills the write that cycle.
    assign mem_we    = (state == ACCESS) & lat_we & ~lat_err & ~rst;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    // Sequencer: latch on handshake, access memory for one cycle, respond for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            lat_port   <= 1'b0;
            lat_err    <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (|hs_bits) begin
                        lat_addr   <= sel_addr;
                        lat_wdata  <= sel_wdata;
                        lat_we     <= sel_we;
                        lat_port   <= hs_port;
                        lat_err    <= sel_err;
                        last_grant <= hs_port;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    rsp_rdata <= (lat_we | lat_err) ? 32'h0 : mem_rdata;
                    rsp_err   <= lat_err;
                    rsp_valid <= lat_port ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a reference memory model
module tb_dmem_arbiter;

    localparam int MEM_WORDS = 4096;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        req_we0;
    logic [31:0] req_addr0;
    logic [31:0] req_wdata0;
    logic        req_we1;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata1;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .IDX_W(12)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we0(req_we0), .req_addr0(req_addr0), .req_wdata0(req_wdata0),
        .req_we1(req_we1), .req_addr1(req_addr1), .req_wdata1(req_wdata1),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory seen by the DUT
    logic [31:0] mem [0:MEM_WORDS-1];
    assign mem_rdata = mem[mem_addr[13:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[13:2]] = mem_wdata;

    // Reference model state
    typedef struct {
        logic        port;
        logic        wr;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic [31:0] ref_mem [0:MEM_WORDS-1];
    exp_t        sbq[$];
    int          cyc;
    int          next_ok;
    logic        mdl_last;
    int          n_cmp;
    int          n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 4 * MEM_WORDS);
    endfunction

    // Monitor: checks responses, memory strobes and grants each cycle against the model
    always @(negedge clk) begin
        logic [1:0] er;
        logic [1:0] hsb;
        logic       exp_we;
        exp_t       e;
        cyc++;
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
            e = sbq.pop_front();
            chk("rsp_missing", 32'(rsp_valid), e.port ? 32'd2 : 32'd1);
        end
        if (rsp_valid != 2'b00) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_port", 32'(rsp_valid), e.port ? 32'd2 : 32'd1);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_latency", 32'(cyc), 32'(e.due));
            end
        end
        exp_we = 1'b0;
        if (sbq.size() > 0 && sbq[0].due == cyc + 1 && sbq[0].wr && !sbq[0].err && !rst)
            exp_we = 1'b1;
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) begin
            chk("mem_addr", mem_addr, sbq[0].addr);
            chk("mem_wdata", mem_wdata, sbq[0].wdata);
            ref_mem[sbq[0].addr[13:2]] = sbq[0].wdata;
        end
        if (!rst) begin
            if (cyc < next_ok) er = 2'b00;
            else if (req_valid == 2'b11) er = mdl_last ? 2'b01 : 2'b10;
            else er = req_valid;
            chk("req_ready", 32'(req_ready), 32'(er));
            hsb = req_valid & er;
            if (hsb != 2'b00) begin
                e.port  = hsb[1];
                e.wr    = e.port ? req_we1 : req_we0;
                e.addr  = e.port ? req_addr1 : req_addr0;
                e.wdata = e.port ? req_wdata1 : req_wdata0;
                e.err   = addr_bad(e.addr);
                e.rdata = (e.wr || e.err) ? 32'h0 : ref_mem[e.addr[13:2]];
                e.due   = cyc + 2;
                sbq.push_back(e);
                mdl_last = e.port;
                next_ok  = cyc + 3;
            end
        end else begin
            sbq.delete();
            mdl_last = 1'b1;
            next_ok  = cyc + 1;
        end
    end

    task automatic set_port(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req_we0 = we; req_addr0 = a; req_wdata0 = d;
        end else begin
            req_we1 = we; req_addr1 = a; req_wdata1 = d;
        end
    endtask

    // Present a request and hold it until accepted (bounded wait)
    task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        bit got;
        got = 1'b0;
        set_port(p, we, a, d);
        req_valid[p] = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[p]) got = 1'b1;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: port %0d got no ready, required ready within 20 cycles", p);
        end
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return {18'h0, 12'($urandom_range(0, 4095)), 2'($urandom_range(1, 3))};
        if (r == 1) return $urandom | 32'h0000_4000;
        return {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
    endfunction

    initial begin
        int bad_words;
        n_cmp = 0; n_bad = 0; cyc = 0; next_ok = 0; mdl_last = 1'b1;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = i * 32'h9E37_79B1;
            ref_mem[i] = i * 32'h9E37_79B1;
        end
        mem[MEM_WORDS-1]     = 32'd10;
        ref_mem[MEM_WORDS-1] = 32'd10;
        rst = 1'b1; req_valid = 2'b00;
        set_port(0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 32'h0, 32'h0);

        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write then read back through port 0
        issue(0, 1'b1, 32'h2000, 32'hDEAD_BEEF);
        issue(0, 1'b0, 32'h2000, 32'h0);
        // Last word and word 0 reads
        issue(0, 1'b0, 32'h3FFC, 32'h0);
        issue(1, 1'b0, 32'h0, 32'h0);
        // Misaligned and out-of-range writes from port 1
        issue(1, 1'b1, 32'h2002, 32'h1111_2222);
        issue(1, 1'b1, 32'h4000, 32'h3333_4444);

        // Reset in the ACCESS cycle of a write, then a tie that must go to port 0
        issue(0, 1'b1, 32'h0100, 32'h1234_5678);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_port(0, 1'b0, 32'h0100, 32'h0);
        set_port(1, 1'b0, 32'h0200, 32'h0);
        req_valid = 2'b11;
        @(negedge clk);
        chk("tie_after_reset", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Both ports request every cycle with distinct addresses
        for (int i = 0; i < 24; i++) begin
            set_port(0, 1'($urandom), {18'h0, 1'b0, 11'($urandom), 2'b00}, $urandom);
            set_port(1, 1'($urandom), {18'h0, 1'b1, 11'($urandom), 2'b00}, $urandom);
            req_valid = 2'b11;
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // Port 1 streams continuously while port 0 asks once
        set_port(1, 1'b0, 32'h0040, 32'h0);
        req_valid[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        issue(0, 1'b0, 32'h0080, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic with occasional resets and dropped requests
        for (int i = 0; i < 400; i++) begin
            req_valid = 2'($urandom);
            set_port(0, 1'($urandom), rand_addr(), $urandom);
            set_port(1, 1'($urandom), rand_addr(), $urandom);
            rst = ($urandom_range(0, 49) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        req_valid = 2'b00;
        repeat (6) @(posedge clk);
        @(negedge clk);

        chk("queue_drained", 32'(sbq.size()), 32'd0);
        bad_words = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        chk("mem_image", 32'(bad_words), 32'd0);
        chk("word2048", mem[2048], 32'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
